// File: rtl/fetch_queue_if.sv
// fetch_queue_if: request/acknowledge instruction memory port between fetch front end and memory.
interface fetch_queue_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  modport master (output mem_req, mem_addr, input mem_ack, mem_rdata);
  modport slave (input mem_req, mem_addr, output mem_ack, mem_rdata);
endinterface

// File: rtl/fetch_queue.sv
// fetch_queue: MIPS fetch front end with prefetch queue feeding the IF/ID register.
// Optional FETCH_BYPASS_EN: ack data goes straight to IF/ID when the queue is empty, back-to-back requests.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                    clock,
  input  logic                    reset,
  fetch_queue_if.master           mem,
  input  logic                    stall,
  input  logic                    redirect,
  input  logic [31:0]             redirect_pc,
  output logic [31:0]             ir_out,
  output logic [31:0]             pc4_out,
  output logic                    ir_valid,
  output logic [$clog2(DEPTH):0]  q_count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, REQ = 2'd1, SQUASH = 2'd2;
  logic [1:0] state_q, state_d;
  logic [31:0] fpc_q, fpc_d, addr_q, addr_d, ir_q, ir_d, pc4_q, pc4_d, next_pc;
  logic valid_q, valid_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0] cnt_q, cnt_d;
  logic [31:0] inst_q [DEPTH];
  logic [31:0] link_q [DEPTH];
  logic ack, take, bypass, push, pop, issue, cont;
  always_comb begin
    next_pc = addr_q + 32'd4;
    ack = mem.mem_ack && state_q != IDLE;
    take = mem.mem_ack && state_q == REQ && !redirect;
`ifdef FETCH_BYPASS_EN
    bypass = take && !stall && cnt_q == '0;
`else
    bypass = 1'b0;
`endif
    push = take && !bypass;
    pop = !redirect && !stall && cnt_q != '0;
    cnt_d = redirect ? '0 : cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    wr_d = wr_q + AW'(push);
    rd_d = redirect ? wr_q : rd_q + AW'(pop);
`ifdef FETCH_BYPASS_EN
    cont = take && cnt_d < FULL;
`else
    cont = 1'b0;
`endif
    // a redirect seen while idle only retargets fpc; the fetch starts next cycle
    issue = state_q == IDLE && !redirect && cnt_q < FULL;
    state_d = (issue || cont) ? REQ :
              (state_q == REQ && redirect && !mem.mem_ack) ? SQUASH :
              ack ? IDLE : state_q;
    addr_d = issue ? fpc_q : cont ? next_pc : addr_q;
    fpc_d = redirect ? redirect_pc : take ? next_pc : fpc_q;
    ir_d = redirect ? '0 : stall ? ir_q : bypass ? mem.mem_rdata : pop ? inst_q[rd_q] : '0;
    pc4_d = (redirect || stall) ? pc4_q : bypass ? next_pc : pop ? link_q[rd_q] : pc4_q;
    valid_d = redirect ? 1'b0 : stall ? valid_q : (bypass || pop);
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      fpc_q <= RESET_PC;
      addr_q <= RESET_PC;
      ir_q <= '0;
      pc4_q <= '0;
      valid_q <= 1'b0;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      fpc_q <= fpc_d;
      addr_q <= addr_d;
      ir_q <= ir_d;
      pc4_q <= pc4_d;
      valid_q <= valid_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clock) begin
    if (push) begin
      inst_q[wr_q] <= mem.mem_rdata;
      link_q[wr_q] <= next_pc;
    end
  end
  assign mem.mem_req = state_q != IDLE;
  assign mem.mem_addr = addr_q;
  assign ir_out = ir_q;
  assign pc4_out = pc4_q;
  assign ir_valid = valid_q;
  assign q_count = cnt_q;
endmodule
